// File: rtl/single_port_lutram_ctrl.sv
// Zero-sweeps the single-port LUTRAM after reset, then arbitrates write/read requests onto its port.
// Read response 1 cycle after acceptance, held until ack; define LUTRAM_CTRL_READ_PRIORITY_EN for read-wins arbitration.
module single_port_lutram_ctrl #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  output logic                                   init_done_out,
  input  logic                                   write_valid_in,
  output logic                                   write_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  input  logic                                   read_valid_in,
  output logic                                   read_ready_out,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       read_set_addr_in,
  output logic                                   read_resp_valid_out,
  input  logic                                   read_resp_ack_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_resp_element_out,
  output logic                                   lutram_access_en_out,
  output logic                                   lutram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       lutram_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lutram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] lutram_read_element_in
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

  state_t                                 state_q, state_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]       sweep_ptr_q, sweep_ptr_d;
  logic                                   init_done_q, init_done_d;
  logic                                   resp_vld_q, resp_vld_d;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_dat_q, resp_dat_d;
  logic                                   slot_free;
  logic                                   wr_gnt;
  logic                                   rd_gnt;

  // A response slot frees up in the same cycle it is acked, so reads can stream back-to-back.
  always_comb begin
    slot_free = !resp_vld_q || read_resp_ack_in;
`ifdef LUTRAM_CTRL_READ_PRIORITY_EN
    rd_gnt = (state_q == ST_RUN) && read_valid_in && slot_free;
    wr_gnt = (state_q == ST_RUN) && write_valid_in && !rd_gnt;
`else
    wr_gnt = (state_q == ST_RUN) && write_valid_in;
    rd_gnt = (state_q == ST_RUN) && read_valid_in && !write_valid_in && slot_free;
`endif
  end

  always_comb begin
    lutram_access_en_out     = 1'b0;
    lutram_write_en_out      = 1'b0;
    lutram_set_addr_out      = '0;
    lutram_write_element_out = '0;
    if (state_q == ST_INIT) begin
      lutram_access_en_out = 1'b1;
      lutram_write_en_out  = 1'b1;
      lutram_set_addr_out  = sweep_ptr_q;
    end else if (wr_gnt) begin
      lutram_access_en_out     = 1'b1;
      lutram_write_en_out      = 1'b1;
      lutram_set_addr_out      = write_set_addr_in;
      lutram_write_element_out = write_element_in;
    end else if (rd_gnt) begin
      lutram_access_en_out = 1'b1;
      lutram_set_addr_out  = read_set_addr_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    init_done_d = init_done_q;
    resp_vld_d  = resp_vld_q;
    resp_dat_d  = resp_dat_q;
    if (state_q == ST_INIT) begin
      sweep_ptr_d = sweep_ptr_q + 1'b1;
      // Terminal compare against the last set keeps non-power-of-two arrays in range.
      if (sweep_ptr_q == LAST_SET) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
        sweep_ptr_d = '0;
      end
    end
    if (rd_gnt) begin
      resp_vld_d = 1'b1;
      resp_dat_d = lutram_read_element_in;
    end else if (read_resp_ack_in) begin
      resp_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_INIT;
      sweep_ptr_q <= '0;
      init_done_q <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_dat_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      init_done_q <= init_done_d;
      resp_vld_q  <= resp_vld_d;
      resp_dat_q  <= resp_dat_d;
    end
  end

  assign init_done_out         = init_done_q;
  assign write_ready_out       = wr_gnt;
  assign read_ready_out        = rd_gnt;
  assign read_resp_valid_out   = resp_vld_q;
  assign read_resp_element_out = resp_dat_q;

endmodule

// File: doc/single_port_lutram_ctrl.md
Name: single_port_lutram_ctrl

Overview:
- Front-end controller that sits directly upstream of the team's single-port LUTRAM storage and drives its access port.
- After reset it clears every set with a zero-write sweep. It then arbitrates independent write and read request channels (valid/ready) onto the one RAM port.
- Returns read data through a registered response channel with backpressure.
- Used by TLB/cache tag arrays that need a guaranteed zeroed array and a clean request handshake.

Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, width of one stored element.
- NUMBER_SETS, 64, number of RAM sets; must be at least 2.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), set address width.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- init_done_out  output  1  high once the clear sweep has completed.
- write_valid_in  input  1  write request valid.
- write_ready_out  output  1  write request accepted this cycle.
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write set address.
- write_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- read_valid_in  input  1  read request valid.
- read_ready_out  output  1  read request accepted this cycle.
- read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read set address.
- read_resp_valid_out  output  1  read response valid.
- read_resp_ack_in  input  1  consumer accepts the response.
- read_resp_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  read response data.
- lutram_access_en_out  output  1  to RAM access_en_in.
- lutram_write_en_out  output  1  to RAM write_en_in.
- lutram_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to RAM access_set_addr_in.
- lutram_write_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  to RAM write_element_in.
- lutram_read_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  from RAM read_element_out (combinational read).

Behaviour:
- Clock and reset:
  - One clock, clk_in.
  - reset_in is asynchronous and active-high.
  - Reset values: state=INIT, sweep pointer=0, init_done_out=0, read_resp_valid_out=0, read_resp_element_out=0.
- State INIT:
  - Each cycle drives lutram_access_en_out=1, lutram_write_en_out=1, lutram_set_addr_out=sweep pointer, lutram_write_element_out=0.
  - Pointer increments by 1 per cycle.
  - After writing set NUMBER_SETS-1, the next state is RUN and init_done_out=1 from that edge onward.
  - Sweep takes exactly NUMBER_SETS cycles.
  - write_ready_out=0 and read_ready_out=0 throughout INIT.
- State RUN, arbitration (combinational per cycle):
  - The write channel is granted when write_valid_in=1.
  - The read channel is granted when read_valid_in=1, no write is granted, and the response slot is free.
  - Response slot is free when read_resp_valid_out=0, or read_resp_valid_out=1 and read_resp_ack_in=1 this cycle.
  - write_ready_out = write grant.
  - read_ready_out = read grant.
  - Fixed write priority; a pending read stalls while writes continue.
- Write grant:
  - access_en=1, write_en=1, addr=write_set_addr_in, data=write_element_in.
  - The RAM updates at the next edge.
- Read grant:
  - access_en=1, write_en=0, addr=read_set_addr_in.
  - lutram_read_element_in is captured into read_resp_element_out at the next edge and read_resp_valid_out is set.
  - Latency is 1 cycle from acceptance to response valid.
- No grant:
  - access_en=0, write_en=0, address and data driven to 0.
- Response channel:
  - read_resp_valid_out clears on the edge where read_resp_ack_in=1, unless a new read is accepted in the same cycle, in which case it stays 1 with the new data.
  - Data is held stable while valid=1 and ack=0.
- Ordering:
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
  - A same-cycle write/read conflict resolves as write first, then read next cycle, which returns the new data.
- State RUN is permanent until reset.
- Reset asserted mid-sweep or mid-response: returns to INIT immediately, sweep restarts from set 0, and any pending response is discarded.
- Sweep pointer is SET_PTR_WIDTH_IN_BITS wide. The terminal compare is against NUMBER_SETS-1, so non-power-of-two set counts never access out-of-range addresses.

Optional Feature:
- Macro: LUTRAM_CTRL_READ_PRIORITY_EN.
- Defined: the read channel wins conflicts. The write is granted only when read_valid_in=0 or the response slot is busy. A read accepted in the same cycle as a pending write returns the old data.
- Undefined: fixed write priority as described in Behaviour.
- INIT behaviour is identical in both builds.

Test Plan:
- Reset then idle, NUMBER_SETS=64 -> lutram_write_en_out=1 for exactly 64 cycles with addresses 0..63 and data 0, then init_done_out=1; any read of set 17 returns 0.
- After init: write set 5 = 0xDEADBEEF_CAFEF00D, then read set 5 next cycle -> read_resp_valid_out=1 exactly one cycle after read acceptance, data 0xDEADBEEF_CAFEF00D.
- Same-cycle write set 9 = 0x1234 and read set 9 -> write_ready_out=1, read_ready_out=0; read accepted next cycle returns 0x1234 (with LUTRAM_CTRL_READ_PRIORITY_EN: read accepted first, returns 0).
- Response backpressure: read set 3 (0xAA), hold read_resp_ack_in=0 for 4 cycles with read_valid_in=1 for set 4 -> read_ready_out=0, data held at 0xAA; ack -> set-4 read accepted in the same cycle, valid stays 1, data updates next edge.
- Assert reset_in at sweep pointer 30 -> outputs clear asynchronously; after release the sweep restarts at set 0 and takes 64 full cycles.
- Back-to-back reads to sets 0..7 with ack held at 1 -> one response per cycle, no bubbles, data matches prior writes.
